// File: rtl/sha256_block_builder.sv
// rtl/sha256_block_builder.sv - reads a message from memory and emits SHA-256 padded 512-bit blocks
module sha256_block_builder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         mem_rd,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         busy,
  output logic         done
);

  localparam int          NB        = (NUM_OF_WORDS + 2) / 16 + 1;
  localparam logic [15:0] MSG_WORDS = 16'(NUM_OF_WORDS);
  localparam logic [11:0] LAST_BLK  = 12'(NB - 1);
  localparam logic [31:0] LEN_BITS  = 32'(NUM_OF_WORDS * 32);
  localparam logic [31:0] PAD_MARK  = 32'h8000_0000;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRESENT, S_DONE} state_t;

  state_t       state, state_nxt;
  logic [15:0]  base_addr;
  logic [15:0]  mem_addr_q;
  logic [11:0]  blk_idx;
  logic [4:0]   slot;
  logic [511:0] blk_q;
  logic [15:0]  issue_g;
  logic [15:0]  cap_g;
  logic [3:0]   cap_j;
  logic         last_blk;
  logic [31:0]  cap_word;

  // Slot k issues word k; slot k+1 captures word k (slot 16 wraps cap_j to 15).
  assign issue_g  = {blk_idx, slot[3:0]};
  assign cap_j    = slot[3:0] - 4'd1;
  assign cap_g    = {blk_idx, cap_j};
  assign last_blk = (blk_idx == LAST_BLK);
  assign blk_data = blk_q;

  // Value of the word being captured: message data, pad marker, length or zero fill.
  always_comb begin
    cap_word = '0;
    if (cap_g < MSG_WORDS) begin
      cap_word = mem_read_data;
    end else if (cap_g == MSG_WORDS) begin
      cap_word = PAD_MARK;
    end else if (last_blk && (cap_j == 4'd15)) begin
      cap_word = LEN_BITS;
    end
  end

  // State register; reset aborts any message in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = mem_addr_q;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        busy = 1'b1;
        if (!slot[4] && (issue_g < MSG_WORDS)) begin
          mem_rd   = 1'b1;
          mem_addr = base_addr + issue_g;
        end
        if (slot == 5'd16) begin
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        busy      = 1'b1;
        blk_valid = 1'b1;
        blk_last  = last_blk;
        if (blk_ready) begin
          state_nxt = last_blk ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch base address, run the fill schedule, shift words into the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_addr  <= '0;
      mem_addr_q <= '0;
      blk_idx    <= '0;
      slot       <= '0;
      blk_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_addr <= message_addr;
            blk_idx   <= '0;
            slot      <= '0;
          end
        end
        S_FILL: begin
          if (mem_rd) begin
            mem_addr_q <= mem_addr;
          end
          if (slot != 5'd0) begin
            blk_q <= {blk_q[479:0], cap_word};
          end
          slot <= (slot == 5'd16) ? 5'd0 : slot + 5'd1;
        end
        S_PRESENT: begin
          if (blk_ready && !last_blk) begin
            blk_idx <= blk_idx + 12'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_builder.sv
// tb/tb_sha256_block_builder.sv - scoreboard bench over three message lengths
module tb_sha256_block_builder;

  function automatic int nw_of(input int i);
    return (i == 0) ? 20 : ((i == 1) ? 13 : 14);
  endfunction

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [15:0]  message_addr;
  logic         blk_ready;

  logic         mem_rd_w    [3];
  logic [15:0]  mem_addr_w  [3];
  logic         blk_valid_w [3];
  logic [511:0] blk_data_w  [3];
  logic         blk_last_w  [3];
  logic         busy_w      [3];
  logic         done_w      [3];

  logic [31:0]  mem [0:65535];
  logic [512:0] exp_q [3][$];

  int total = 0;
  int bad = 0;
  int timeouts = 0;
  bit tests_over = 1'b0;

  int cyc_n = 0;
  bit in_msg [3];
  bit prev_valid [3];
  bit prev_xfer [3];
  bit prev_done [3];
  int start_cyc [3];
  int xfer_cyc [3];
  int rd_cnt [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    logic [31:0] rd_q;
    always @(posedge clk) begin
      if (mem_rd_w[gi]) rd_q <= mem[mem_addr_w[gi]];
      else              rd_q <= $urandom;
    end
    sha256_block_builder #(.NUM_OF_WORDS(nw_of(gi))) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .message_addr (message_addr),
      .mem_rd       (mem_rd_w[gi]),
      .mem_addr     (mem_addr_w[gi]),
      .mem_read_data(rd_q),
      .blk_valid    (blk_valid_w[gi]),
      .blk_ready    (blk_ready),
      .blk_data     (blk_data_w[gi]),
      .blk_last     (blk_last_w[gi]),
      .busy         (busy_w[gi]),
      .done         (done_w[gi])
    );
  end

  task automatic check(input string name, input int inst, input logic [543:0] act, input logic [543:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%0h want=%0h", name, inst, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [15:0] base, input bit ident);
    for (int k = 0; k < 48; k++) begin
      logic [15:0] a;
      a = base + 16'(k);
      mem[a] = ident ? {16'h0000, a} : $urandom;
    end
  endtask

  // Reference: build every padded block straight from the word-value rules.
  task automatic push_expect(input logic [15:0] base);
    for (int i = 0; i < 3; i++) begin
      int n;
      int nb;
      int g;
      logic [511:0] blk;
      logic [31:0] w;
      n  = nw_of(i);
      nb = (n + 2) / 16 + 1;
      for (int b = 0; b < nb; b++) begin
        blk = '0;
        for (int j = 0; j < 16; j++) begin
          g = 16 * b + j;
          if (g < n)                        w = mem[16'(int'(base) + g)];
          else if (g == n)                  w = 32'h8000_0000;
          else if (b == nb - 1 && j == 15)  w = 32'(n * 32);
          else                              w = 32'h0;
          blk[511 - 32 * j -: 32] = w;
        end
        exp_q[i].push_back({(b == nb - 1), blk});
      end
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++) begin
      if (busy_w[i] || done_w[i] || exp_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // mode 0: ready held high; 1: ready low for 10 cycles of block 0 PRESENT; 2: random ready.
  task automatic run_msg(input logic [15:0] base, input int mode, input bit poke, input bit ident);
    int c;
    bit finished;
    fill_mem(base, ident);
    push_expect(base);
    @(posedge clk); #1;
    start = 1'b1;
    message_addr = base;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    message_addr = 16'($urandom);
    c = 1;
    finished = 1'b0;
    while (!finished && c < 3000) begin
      if (mode == 0)      blk_ready = 1'b1;
      else if (mode == 1) blk_ready = !(c >= 18 && c < 28);
      else                blk_ready = 1'($urandom_range(0, 1));
      start = poke && (c == 19);
      if (start) message_addr = ~base;
      @(posedge clk); #1;
      c++;
      if (c > 2 && all_idle()) finished = 1'b1;
    end
    start = 1'b0;
    if (!finished) timeouts++;
  endtask

  // Stimulus.
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    message_addr = '0;
    blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_msg(16'h0100, 0, 1'b0, 1'b1);
    run_msg(16'h0200, 1, 1'b0, 1'b1);
    run_msg(16'h0300, 0, 1'b1, 1'b1);

    fill_mem(16'h0400, 1'b1);
    push_expect(16'h0400);
    @(posedge clk); #1;
    start = 1'b1;
    message_addr = 16'h0400;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run_msg(16'h0500, 0, 1'b0, 1'b1);

    run_msg(16'hFFF0, 2, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) begin
      run_msg(16'($urandom), 2, 1'b0, 1'b0);
    end
    tests_over = 1'b1;
  end

  // Monitor: compares everything the DUTs present against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        check("reset_outputs", i,
              544'({mem_rd_w[i], mem_addr_w[i], blk_valid_w[i], blk_data_w[i],
                    blk_last_w[i], busy_w[i], done_w[i]}), 544'(0));
        in_msg[i] = 1'b0;
        prev_valid[i] = 1'b0;
        prev_xfer[i] = 1'b0;
        prev_done[i] = 1'b0;
      end else begin
        if (in_msg[i] && !done_w[i]) check("busy_high", i, busy_w[i], 1);
        if (prev_done[i]) check("done_one_cycle", i, done_w[i], 0);
        if (start && !busy_w[i] && !done_w[i]) begin
          in_msg[i] = 1'b1;
          start_cyc[i] = cyc_n;
          xfer_cyc[i] = -1;
          rd_cnt[i] = 0;
        end
        if (mem_rd_w[i]) rd_cnt[i]++;
        if (prev_xfer[i]) check("valid_drop", i, blk_valid_w[i], 0);
        if (blk_valid_w[i] && !prev_valid[i]) begin
          check("valid_rise_latency", i,
                cyc_n - ((xfer_cyc[i] < 0) ? start_cyc[i] : xfer_cyc[i]), 18);
        end
        if (blk_valid_w[i]) begin
          check("no_rd_in_present", i, mem_rd_w[i], 0);
          if (exp_q[i].size() == 0) begin
            check("unexpected_block", i, 1, 0);
          end else begin
            check("block", i, {blk_last_w[i], blk_data_w[i]}, exp_q[i][0]);
            if (blk_ready) begin
              void'(exp_q[i].pop_front());
              xfer_cyc[i] = cyc_n;
            end
          end
        end
        if (done_w[i]) begin
          check("done_latency", i, cyc_n - xfer_cyc[i], 1);
          check("busy_at_done", i, busy_w[i], 0);
          check("mem_rd_count", i, rd_cnt[i], nw_of(i));
          check("blocks_outstanding", i, exp_q[i].size(), 0);
          in_msg[i] = 1'b0;
        end
        prev_valid[i] = blk_valid_w[i];
        prev_xfer[i] = blk_valid_w[i] && blk_ready;
        prev_done[i] = done_w[i];
      end
    end
    if (tests_over) begin
      check("timeouts", -1, timeouts, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    cyc_n++;
  end

endmodule
